// File: rtl/alu_seq_unit.sv
// Sequential RV32I ALU with optional M extension: decodes aluop/funct3/funct7,
// executes single-cycle base ops or an iterative mul/div, and returns a registered result.
module alu_seq_unit #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1,
    parameter int SHW      = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      aluop,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [4:0]      alu_control,
    output logic            busy
);

    localparam logic [4:0] C_ADD    = 5'd0;
    localparam logic [4:0] C_SUB    = 5'd1;
    localparam logic [4:0] C_AND    = 5'd2;
    localparam logic [4:0] C_OR     = 5'd3;
    localparam logic [4:0] C_XOR    = 5'd4;
    localparam logic [4:0] C_SLT    = 5'd5;
    localparam logic [4:0] C_SLTU   = 5'd6;
    localparam logic [4:0] C_SLL    = 5'd7;
    localparam logic [4:0] C_SRL    = 5'd8;
    localparam logic [4:0] C_SRA    = 5'd9;
    localparam logic [4:0] C_MUL    = 5'd10;
    localparam logic [4:0] C_MULH   = 5'd11;
    localparam logic [4:0] C_MULHSU = 5'd12;
    localparam logic [4:0] C_MULHU  = 5'd13;
    localparam logic [4:0] C_DIV    = 5'd14;
    localparam logic [4:0] C_DIVU   = 5'd15;
    localparam logic [4:0] C_REM    = 5'd16;
    localparam logic [4:0] C_REMU   = 5'd17;

    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_reg, state_next;
    logic              accept;
    logic [4:0]        dec_code;
    logic              dec_is_m;
    logic [XLEN-1:0]   base_res;
    logic [SHW-1:0]    shamt;

    logic [4:0]        ctrl_reg;
    logic [XLEN-1:0]   result_reg;
    logic              zero_reg;
    logic [XLEN-1:0]   a_reg, b_reg;
    logic [XLEN-1:0]   hi_reg, lo_reg, opnd_reg;
    logic [SHW-1:0]    cnt_reg;
    logic              neg_reg, neg_r_reg, is_div_reg;

    // ---------------- decode ----------------
    always_comb begin
        dec_code = C_ADD;
        case (aluop)
            2'b00: dec_code = C_ADD;
            2'b01: dec_code = C_SUB;
            default: begin
                case (funct3)
                    3'b000:  dec_code = (aluop == 2'b10 && funct7[5]) ? C_SUB : C_ADD;
                    3'b001:  dec_code = C_SLL;
                    3'b010:  dec_code = C_SLT;
                    3'b011:  dec_code = C_SLTU;
                    3'b100:  dec_code = C_XOR;
                    3'b101:  dec_code = funct7[5] ? C_SRA : C_SRL;
                    3'b110:  dec_code = C_OR;
                    default: dec_code = C_AND;
                endcase
                if (ENABLE_M && aluop == 2'b10 && funct7 == 7'b0000001)
                    dec_code = C_MUL + {2'b00, funct3};
            end
        endcase
    end

    assign dec_is_m = (dec_code >= C_MUL);
    assign shamt    = op_b[SHW-1:0];

    // ---------------- single-cycle ops ----------------
    always_comb begin
        base_res = '0;
        case (dec_code)
            C_ADD:  base_res = op_a + op_b;
            C_SUB:  base_res = op_a - op_b;
            C_AND:  base_res = op_a & op_b;
            C_OR:   base_res = op_a | op_b;
            C_XOR:  base_res = op_a ^ op_b;
            C_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            C_SLTU: base_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            C_SLL:  base_res = op_a << shamt;
            C_SRL:  base_res = op_a >> shamt;
            C_SRA:  base_res = $signed(op_a) >>> shamt;
            default: base_res = '0;
        endcase
    end

    // ---------------- iterative operand setup ----------------
    logic            sgn_a, sgn_b, a_neg, b_neg, in_is_div;
    logic [XLEN-1:0] a_mag, b_mag;

    assign sgn_a     = (dec_code == C_MUL) || (dec_code == C_MULH) || (dec_code == C_MULHSU) ||
                       (dec_code == C_DIV) || (dec_code == C_REM);
    assign sgn_b     = (dec_code == C_MUL) || (dec_code == C_MULH) ||
                       (dec_code == C_DIV) || (dec_code == C_REM);
    assign a_neg     = sgn_a & op_a[XLEN-1];
    assign b_neg     = sgn_b & op_b[XLEN-1];
    assign a_mag     = a_neg ? (~op_a + 1'b1) : op_a;
    assign b_mag     = b_neg ? (~op_b + 1'b1) : op_b;
    assign in_is_div = (dec_code >= C_DIV);

    // ---------------- one mul/div iteration ----------------
    logic [XLEN:0]   madd, trial, diff;
    logic            ge;
    logic [XLEN-1:0] hi_n, lo_n;

    assign madd  = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
    assign trial = {hi_reg, lo_reg[XLEN-1]};
    assign diff  = trial - {1'b0, opnd_reg};
    assign ge    = ~diff[XLEN];
    assign hi_n  = is_div_reg ? (ge ? diff[XLEN-1:0] : trial[XLEN-1:0]) : madd[XLEN:1];
    assign lo_n  = is_div_reg ? {lo_reg[XLEN-2:0], ge} : {madd[0], lo_reg[XLEN-1:1]};

    // ---------------- sign fix and special cases ----------------
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, m_res;
    logic              div_zero, div_ovf;

    assign prod     = {hi_n, lo_n};
    assign prod_s   = neg_reg ? (~prod + 1'b1) : prod;
    assign quo_s    = neg_reg ? (~lo_n + 1'b1) : lo_n;
    assign rem_s    = neg_r_reg ? (~hi_n + 1'b1) : hi_n;
    assign div_zero = (b_reg == '0);
    assign div_ovf  = (a_reg == XMIN) && (b_reg == '1);

    always_comb begin
        m_res = '0;
        case (ctrl_reg)
            C_MUL:                     m_res = prod_s[XLEN-1:0];
            C_MULH, C_MULHSU, C_MULHU: m_res = prod_s[2*XLEN-1:XLEN];
            C_DIV:   m_res = div_zero ? '1   : (div_ovf ? XMIN : quo_s);
            C_DIVU:  m_res = div_zero ? '1   : quo_s;
            C_REM:   m_res = div_zero ? a_reg : (div_ovf ? '0 : rem_s);
            C_REMU:  m_res = div_zero ? a_reg : rem_s;
            default: m_res = '0;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = dec_is_m ? CALC : DONE;
            CALC: if (cnt_reg == '0) state_next = DONE;
            DONE: begin
                if (accept)         state_next = dec_is_m ? CALC : DONE;
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE) || (state_reg == DONE && out_ready);
        out_valid = (state_reg == DONE);
        busy      = (state_reg == CALC);
    end

    assign accept = in_valid & in_ready;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_reg   <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b1;
            a_reg      <= '0;
            b_reg      <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            opnd_reg   <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
            neg_r_reg  <= 1'b0;
            is_div_reg <= 1'b0;
        end else if (accept) begin
            ctrl_reg   <= dec_code;
            a_reg      <= op_a;
            b_reg      <= op_b;
            hi_reg     <= '0;
            lo_reg     <= in_is_div ? a_mag : b_mag;
            opnd_reg   <= in_is_div ? b_mag : a_mag;
            cnt_reg    <= SHW'(XLEN-1);
            neg_reg    <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
            is_div_reg <= in_is_div;
            if (!dec_is_m) begin
                result_reg <= base_res;
                zero_reg   <= (base_res == '0);
            end
        end else if (state_reg == CALC) begin
            hi_reg  <= hi_n;
            lo_reg  <= lo_n;
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == '0) begin
                result_reg <= m_res;
                zero_reg   <= (m_res == '0);
            end
        end
    end

    assign result      = result_reg;
    assign zero        = zero_reg;
    assign alu_control = ctrl_reg;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: vector table for single ops plus hand sequences
// for hold, back-to-back, CALC-time input, reset mid-divide and the ENABLE_M=0 build.
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]  aluop = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        in_ready, out_valid, zero, busy;
    logic [31:0] result;
    logic [4:0]  alu_control;

    logic        n_in_valid = 1'b0, n_out_ready = 1'b0;
    logic        n_in_ready, n_out_valid, n_zero, n_busy;
    logic [31:0] n_result;
    logic [4:0]  n_ctrl;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq_unit #(.XLEN(32), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
        .alu_control(alu_control), .busy(busy)
    );

    alu_seq_unit #(.XLEN(32), .ENABLE_M(1'b0)) dut_nom (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .aluop(aluop), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .result(n_result), .zero(n_zero),
        .alu_control(n_ctrl), .busy(n_busy)
    );

    typedef struct {
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  ctrl;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic void addv(logic [1:0] al, logic [2:0] f3, logic [6:0] f7,
                                 logic [31:0] a, logic [31:0] b, logic [31:0] res,
                                 logic [4:0] ctrl, int lat);
        vec_t v;
        v.aluop = al; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b;
        v.res = res; v.ctrl = ctrl; v.lat = lat;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(logic [1:0] al, logic [2:0] f3, logic [6:0] f7,
                         logic [31:0] a, logic [31:0] b);
        aluop = al; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int stale;
        logic [31:0] bb_exp[4];

        // base ops (latency 1)
        addv(2'b10, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'hFFFFFFFE, 5'd1, 1);
        addv(2'b11, 3'b000, 7'b0100000, 32'd3, 32'd3, 32'd6, 5'd0, 1);
        addv(2'b01, 3'b000, 7'b0000000, 32'd9, 32'd9, 32'd0, 5'd1, 1);
        addv(2'b00, 3'b010, 7'b0000000, 32'h10, 32'h20, 32'h30, 5'd0, 1);
        addv(2'b11, 3'b101, 7'b0100000, 32'h80000000, 32'h24, 32'hF8000000, 5'd9, 1);
        addv(2'b10, 3'b101, 7'b0000000, 32'h80000000, 32'h24, 32'h08000000, 5'd8, 1);
        addv(2'b10, 3'b001, 7'b0000000, 32'd1, 32'h21, 32'd2, 5'd7, 1);
        addv(2'b10, 3'b011, 7'b0000000, 32'd1, 32'hFFFFFFFF, 32'd1, 5'd6, 1);
        addv(2'b10, 3'b010, 7'b0000000, 32'd1, 32'hFFFFFFFF, 32'd0, 5'd5, 1);
        addv(2'b10, 3'b100, 7'b0000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 5'd4, 1);
        addv(2'b10, 3'b110, 7'b0000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 5'd3, 1);
        addv(2'b10, 3'b111, 7'b0000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'd2, 1);
        // M ops (latency 33)
        addv(2'b10, 3'b000, 7'b0000001, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 5'd10, 33);
        addv(2'b10, 3'b011, 7'b0000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd13, 33);
        addv(2'b10, 3'b001, 7'b0000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 5'd11, 33);
        addv(2'b10, 3'b010, 7'b0000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 33);
        addv(2'b10, 3'b100, 7'b0000001, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 5'd14, 33);
        addv(2'b10, 3'b110, 7'b0000001, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 5'd16, 33);
        addv(2'b10, 3'b100, 7'b0000001, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 5'd14, 33);
        addv(2'b10, 3'b110, 7'b0000001, 32'd7, 32'hFFFFFFFE, 32'd1, 5'd16, 33);
        addv(2'b10, 3'b101, 7'b0000001, 32'd5, 32'd0, 32'hFFFFFFFF, 5'd15, 33);
        addv(2'b10, 3'b111, 7'b0000001, 32'd100, 32'd0, 32'd100, 5'd17, 33);
        addv(2'b10, 3'b101, 7'b0000001, 32'd100, 32'd7, 32'd14, 5'd15, 33);
        addv(2'b10, 3'b111, 7'b0000001, 32'd100, 32'd7, 32'd2, 5'd17, 33);
        addv(2'b10, 3'b110, 7'b0000001, 32'h80000000, 32'hFFFFFFFF, 32'd0, 5'd16, 33);
        addv(2'b10, 3'b100, 7'b0000001, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 5'd14, 33);

        // reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset zero", {31'd0, zero}, 32'd1);
        chk("reset alu_control", {27'd0, alu_control}, 32'd0);

        // table-driven single transactions
        foreach (vecs[i]) begin
            drive(vecs[i].aluop, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b);
            in_valid  = 1'b1;
            out_ready = 1'b0;
            chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
            tick();
            in_valid = 1'b0;
            lat = 1;
            busy_cnt = 0;
            while (!out_valid && lat < 100) begin
                if (busy) busy_cnt++;
                tick();
                lat++;
            end
            $display("vec %0d: ctrl=%0d a=%08h b=%08h -> result=%08h zero=%0b lat=%0d",
                     i, alu_control, vecs[i].a, vecs[i].b, result, zero, lat);
            chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d result", i), result, vecs[i].res);
            chk($sformatf("v%0d zero", i), {31'd0, zero}, {31'd0, vecs[i].res == 32'd0});
            chk($sformatf("v%0d alu_control", i), {27'd0, alu_control}, {27'd0, vecs[i].ctrl});
            if (vecs[i].lat > 1)
                chk($sformatf("v%0d busy cycles", i), busy_cnt, 32);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("v%0d drained", i), {31'd0, out_valid}, 32'd0);
        end

        // hold result with out_ready low for 5 cycles
        drive(2'b10, 3'b110, 7'b0, 32'h12, 32'h21);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d out_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("hold%0d result", k), result, 32'h33);
            chk($sformatf("hold%0d in_ready", k), {31'd0, in_ready}, 32'd0);
            tick();
        end
        $display("hold: result=%08h held 5 cycles", result);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // back-to-back base ops, one result per cycle
        bb_exp[0] = 32'd3; bb_exp[1] = 32'd6; bb_exp[2] = 32'hF0; bb_exp[3] = 32'h10;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: drive(2'b00, 3'b000, 7'b0, 32'd1, 32'd2);
                1: drive(2'b01, 3'b000, 7'b0, 32'd10, 32'd4);
                2: drive(2'b10, 3'b100, 7'b0, 32'hFF, 32'h0F);
                default: drive(2'b11, 3'b001, 7'b0, 32'd1, 32'd4);
            endcase
            if (k > 0) begin
                chk($sformatf("b2b%0d out_valid", k - 1), {31'd0, out_valid}, 32'd1);
                chk($sformatf("b2b%0d result", k - 1), result, bb_exp[k-1]);
                $display("b2b %0d: result=%08h", k - 1, result);
            end
            tick();
        end
        // M op accepted from DONE drops out_valid
        drive(2'b10, 3'b000, 7'b0000001, 32'd6, 32'd7);
        chk("b2b3 out_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b3 result", result, bb_exp[3]);
        $display("b2b 3: result=%08h", result);
        tick();
        out_ready = 1'b0;
        chk("m-from-done out_valid", {31'd0, out_valid}, 32'd0);
        chk("m-from-done busy", {31'd0, busy}, 32'd1);
        // new request during CALC must be ignored
        drive(2'b00, 3'b000, 7'b0, 32'd1, 32'd1);
        chk("calc in_ready", {31'd0, in_ready}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        $display("mul during-calc-request: result=%08h lat=%0d", result, lat);
        chk("calc-ignore latency", lat, 33);
        chk("calc-ignore result", result, 32'd42);
        chk("calc-ignore alu_control", {27'd0, alu_control}, 32'd10);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // reset mid-DIV discards the operation
        drive(2'b10, 3'b100, 7'b0000001, 32'd100, 32'd3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst-div out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst-div in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst-div busy", {31'd0, busy}, 32'd0);
        chk("rst-div result", result, 32'd0);
        chk("rst-div zero", {31'd0, zero}, 32'd1);
        chk("rst-div alu_control", {27'd0, alu_control}, 32'd0);
        out_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) stale++;
            tick();
        end
        out_ready = 1'b0;
        chk("rst-div stale results", stale, 0);
        $display("reset mid-div: stale results=%0d", stale);

        // ENABLE_M=0: M pattern falls back to ADD
        drive(2'b10, 3'b000, 7'b0000001, 32'd5, 32'd6);
        n_in_valid = 1'b1;
        tick();
        n_in_valid = 1'b0;
        $display("nom: result=%08h ctrl=%0d valid=%0b", n_result, n_ctrl, n_out_valid);
        chk("nom out_valid", {31'd0, n_out_valid}, 32'd1);
        chk("nom result", n_result, 32'd11);
        chk("nom alu_control", {27'd0, n_ctrl}, 32'd0);
        chk("nom busy", {31'd0, n_busy}, 32'd0);
        n_out_ready = 1'b1;
        tick();
        n_out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
